// File: rtl/mem_types_pkg.sv
// ----------------------------------------------------------------------------
// mem_types
//   Shared definitions for the memory responder slice.
//   - state_t           : responder FSM states
//   - LANES / LANE_BITS : byte-lane geometry of a 32-bit data word
//   - addr_out_of_range : true when a byte address lies above the storage
// ----------------------------------------------------------------------------
package mem_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LANES     = 4;
    localparam int LANE_BITS = 8;

    // Any address bit above the word-index field marks an access
    // outside the backing array.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int          addr_width);
        return (addr >> (addr_width + 2)) != 32'h0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
//   Word-addressed storage, 2^ADDR_WIDTH x 32 bits, built as one byte-wide
//   array per lane so each lane has an independent synchronous write enable.
//   Read is combinational. Contents are not reset.
//
//   clk    in   clock
//   we     in   [3:0]  per-lane write enable
//   addr   in   [ADDR_WIDTH-1:0] word index
//   wdata  in   [31:0] lane-aligned write data
//   rdata  out  [31:0] word at addr
// ----------------------------------------------------------------------------
module mem_array
    import mem_types::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [LANES-1:0]      we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_BITS-1:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*LANE_BITS +: LANE_BITS];
                end
            end

            assign rdata[gi*LANE_BITS +: LANE_BITS] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for a single-port request/response interface.
//   One request at a time; mem_resp pulses for one cycle LATENCY cycles after
//   the request is first seen. Writes commit per byte lane on the edge that
//   enters RESP, so a reset before that point never leaves a partial write.
//
//   clk              in   clock
//   rst              in   asynchronous active-low reset
//   mem_read         in   read request (held until mem_resp)
//   mem_write        in   write request (held until mem_resp)
//   mem_byte_enable  in   [3:0]  write lane mask
//   mem_address      in   [31:0] byte address, bits [1:0] ignored
//   mem_wdata        in   [31:0] lane-aligned write data
//   mem_rdata        out  [31:0] read data, valid with mem_resp
//   mem_resp         out  single-cycle completion pulse
//   mem_err          out  error flag (out of range or read+write), with mem_resp
// ----------------------------------------------------------------------------
module mem_responder
    import mem_types::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        capture;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        rd_reg;
    logic        wr_reg;

    logic [31:0] rdata_reg;
    logic        resp_reg;
    logic        err_reg;

    // Transaction view: live inputs in the capture cycle (needed when
    // LATENCY==1 enters RESP on the capture edge), captured copies otherwise.
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    logic [3:0]  txn_be;
    logic        txn_rd;
    logic        txn_wr;
    logic        txn_err;
    logic        enter_resp;

    logic [LANES-1:0] array_we;
    logic [31:0]      array_rdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_read || mem_write) begin
                    capture = 1'b1;
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                        count_next = COUNT_INIT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                // <= rather than == keeps the FSM from stalling if the
                // counter is ever corrupted to zero.
                if (count_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        txn_addr   = capture ? mem_address     : addr_reg;
        txn_wdata  = capture ? mem_wdata       : wdata_reg;
        txn_be     = capture ? mem_byte_enable : be_reg;
        txn_rd     = capture ? mem_read        : rd_reg;
        txn_wr     = capture ? mem_write       : wr_reg;
        txn_err    = addr_out_of_range(txn_addr, ADDR_WIDTH) || (txn_rd && txn_wr);
        enter_resp = (state_next == RESP) && (state_reg != RESP);
        array_we   = (enter_resp && txn_wr && !txn_err) ? txn_be : '0;
    end

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (txn_addr[ADDR_WIDTH+1:2]),
        .wdata (txn_wdata),
        .rdata (array_rdata)
    );

    // ------------------------------------------------------------------
    // State, capture and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            be_reg    <= 4'h0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            rdata_reg <= 32'h0;
            resp_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (capture) begin
                addr_reg  <= mem_address;
                wdata_reg <= mem_wdata;
                be_reg    <= mem_byte_enable;
                rd_reg    <= mem_read;
                wr_reg    <= mem_write;
            end
            resp_reg <= enter_resp;
            err_reg  <= enter_resp && txn_err;
            // Read data only changes on a completing read or error;
            // a good write leaves the previous value in place.
            if (enter_resp && txn_err) begin
                rdata_reg <= 32'h0;
            end else if (enter_resp && txn_rd) begin
                rdata_reg <= array_rdata;
            end
        end
    end

    assign mem_rdata = rdata_reg;
    assign mem_resp  = resp_reg;
    assign mem_err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;

    logic [31:0] rdata0, rdata1;
    logic        resp0, resp1, err0, err1;

    int compared   = 0;
    int mismatched = 0;
    logic sel = 1'b0;

    wire [31:0] s_rdata = sel ? rdata1 : rdata0;
    wire        s_resp  = sel ? resp1  : resp0;
    wire        s_err   = sel ? err1   : err0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(rdata0), .mem_resp(resp0), .mem_err(err0)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives one request, waits for mem_resp, compares
    // against the scoreboard entry, then checks the pulse is one cycle wide.
    task automatic txn(input logic d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic chk, input logic [31:0] exp_rd, input logic exp_err,
                       input logic hold, input string tag);
        exp_t e;
        int   n;
        sel = d;
        e.rdata = exp_rd; e.chk = chk; e.err = exp_err; e.lat = d ? 1 : 3;
        sb.push_back(e);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
        end while (!s_resp && n < 20);
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_err"}, {31'h0, s_err}, {31'h0, e.err});
        if (e.chk) check({tag, "_rdata"}, s_rdata, e.rdata);
        $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h be=%b -> lat=%0d rdata=%h err=%0b",
                 tag, rd, wr, a, wd, be, n, s_rdata, s_err);
        if (!hold) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        check({tag, "_pulse"}, {31'h0, s_resp}, 32'h0);
    endtask

    initial begin
        int seen;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 4'h0; mem_address = 32'h0; mem_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_resp", {31'h0, resp0}, 32'h0);
        check("reset_err", {31'h0, err0}, 32'h0);
        check("reset_rdata", rdata0, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0, 0, 0, "wr_full");
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEADBEEF, 0, 0, "rd_full");
        txn(0, 0, 1, 32'h13, 32'hAB000000, 4'b1000, 0, 32'h0, 0, 0, "wr_lane3");
        txn(0, 1, 0, 32'h10, 32'h0, 4'b1111, 1, 32'hABADBEEF, 0, 0, "rd_lane3");
        txn(0, 0, 1, 32'h12, 32'h12340000, 4'b1100, 0, 32'h0, 0, 0, "wr_half");
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234BEEF, 0, 0, "rd_half");

        // Held read: second response four cycles after the first.
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234BEEF, 0, 1, "b2b_first");
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234BEEF, 0, 0, "b2b_second");
        seen = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (resp0) seen++;
        end
        check("b2b_no_third", 32'(seen), 32'h0);

        // Out of range: 0x1000 would alias word 0 if the range check failed.
        txn(0, 0, 1, 32'h0, 32'h0BADF00D, 4'b1111, 0, 32'h0, 0, 0, "wr_zero");
        txn(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 0, 32'h0, 1, 0, "wr_oor");
        txn(0, 1, 0, 32'h0, 32'h0, 4'b0000, 1, 32'h0BADF00D, 0, 0, "rd_zero");
        txn(0, 1, 0, 32'h1000, 32'h0, 4'b0000, 1, 32'h0, 1, 0, "rd_oor");

        // Read and write together is an error with no storage access.
        txn(0, 1, 1, 32'h10, 32'h99999999, 4'b1111, 1, 32'h0, 1, 0, "rdwr_err");
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234BEEF, 0, 0, "rd_after_err");

        // Reset while in WAIT drops the write.
        sel = 1'b0;
        mem_write = 1'b1; mem_address = 32'h10; mem_wdata = 32'h55555555; mem_byte_enable = 4'hF;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_resp", {31'h0, resp0}, 32'h0);
        check("midrst_err", {31'h0, err0}, 32'h0);
        check("midrst_rdata", rdata0, 32'h0);
        $display("txn midrst wr addr=%h wdata=%h -> reset in WAIT, rdata=%h resp=%0b",
                 mem_address, mem_wdata, rdata0, resp0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (resp0) seen++;
        end
        check("midrst_no_resp", 32'(seen), 32'h0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234BEEF, 0, 0, "rd_after_rst");

        // LATENCY=1 instance.
        txn(1, 0, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 0, 32'h0, 0, 0, "l1_wr");
        txn(1, 1, 0, 32'h20, 32'h0, 4'b0000, 1, 32'hCAFEF00D, 0, 0, "l1_rd");
        txn(1, 1, 0, 32'h4000, 32'h0, 4'b0000, 1, 32'h0, 1, 0, "l1_rd_oor");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle RV32I core's single-port memory interface (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in, mem_rdata/mem_resp out). It backs a word-addressed storage array and answers one request at a time after a fixed, parameterised latency. Byte lanes are written per mem_byte_enable. Used as the synthesizable memory model behind the CPU in simulation and on FPGA.

Parameters:
ADDR_WIDTH, 10, word-index bits; capacity 2^ADDR_WIDTH words (default 4 KiB)
LATENCY, 3, cycles from first request cycle to mem_resp; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
mem_read  in  1  read request, held by initiator until mem_resp
mem_write  in  1  write request, held by initiator until mem_resp
mem_byte_enable  in  4  write lane mask, bit i = bits [8i+7:8i]
mem_address  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data, already lane-aligned by initiator
mem_rdata  out  32  read data, valid while mem_resp=1
mem_resp  out  1  single-cycle completion pulse
mem_err  out  1  error flag, valid only with mem_resp

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, mem_resp=0, mem_err=0, mem_rdata=32'h0. Storage contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE: if mem_read|mem_write, capture address, wdata, byte_enable, op. Go to WAIT with counter=LATENCY-1 if LATENCY>1; otherwise go to RESP.
- WAIT: decrement counter each cycle; when counter==1, next state is RESP. Inputs are ignored; captured values are used.
- RESP: mem_resp=1 for exactly one cycle, then IDLE.
- Timing: request first seen in cycle t -> mem_resp high in cycle t+LATENCY.
- Back-to-back: a request still high in the IDLE cycle after RESP is a new request.
- Read: mem_rdata = full word at index addr[ADDR_WIDTH+1:2], registered on entry to RESP and held until the next capture. mem_byte_enable is ignored.
- Write: on the edge entering RESP, write lane i iff byte_enable[i]. Unselected lanes are unchanged. mem_rdata is unchanged.
- Out of range: any of addr[31:ADDR_WIDTH+2] nonzero -> normal latency and mem_resp, mem_err=1, read returns 32'h0, write suppressed.
- Both mem_read and mem_write high at capture -> treated as an error: mem_resp with mem_err=1, no storage access, mem_rdata=32'h0.
- Initiator drops its request before mem_resp: the access still completes with the captured values. There is no abort.
- Reset mid-WAIT/RESP: the transaction is dropped with no mem_resp. A write is never partially committed, because commit happens only on RESP entry.
- mem_err=0 whenever mem_resp=0.

Decomposition:
- Shared package mem_types: state enum (IDLE, WAIT, RESP) and lane-count constant (4).
- Sub-module mem_array holds the storage:
  - 2^ADDR_WIDTH x 32 array.
  - Per-lane synchronous write enable.
  - Combinational read.
  - No reset.
- mem_responder owns the FSM, latency counter, range check and output registers.

Test Plan:
- Reset; write addr 0x10, wdata 0xDEADBEEF, be 4'b1111 at cycle t, LATENCY=3 -> mem_resp only at t+3, mem_err=0. Then read 0x10 -> mem_rdata=0xDEADBEEF with mem_resp.
- Write addr 0x13, wdata 0xAB000000, be 4'b1000 -> read 0x10 returns 0xABADBEEF. Write addr 0x12, wdata 0x12340000, be 4'b1100 -> read returns 0x1234BEEF.
- Read held high across mem_resp (resp at t+3) -> second mem_resp at t+7. Verify exactly one-cycle pulses and no spurious third response.
- ADDR_WIDTH=10; write 0x00001000, wdata 0xFFFFFFFF -> mem_resp+mem_err at t+3. Read 0x00000000 afterwards is unchanged. Read 0x00001000 -> rdata 0, err=1.
- mem_read=mem_write=1, addr 0x10 -> mem_resp+mem_err, rdata 0. Read 0x10 still returns 0x1234BEEF.
- Issue a write 0x55555555 to 0x10, assert rst=0 at t+1 (in WAIT) -> mem_resp stays 0 and outputs go to reset values immediately. After release, read 0x10 -> 0x1234BEEF. LATENCY=1 variant: response in the cycle after the request.
